// File: rtl/cmd_frame_pkg.sv
// Shared types, command codes and the argument-length table for the command frame parser.
package cmd_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARG,
    OUT
  } state_t;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] arg;
  } frame_t;

  localparam logic [7:0] CMD_WR_ADDR = "A";
  localparam logic [7:0] CMD_WR_BUS  = "B";
  localparam logic [7:0] CMD_OFF     = "O";
  localparam logic [7:0] CMD_SET_CW  = "M";
  localparam logic [7:0] CMD_RD_OP   = "r";
  localparam logic [7:0] CMD_TIMEOUT = 8'hff;

  // Number of little-endian argument bytes that follow a command byte.
  function automatic logic [2:0] arg_len(input logic [7:0] c);
    case (c)
      CMD_WR_BUS:                     arg_len = 3'd1;
      CMD_WR_ADDR:                    arg_len = 3'd2;
      CMD_OFF, CMD_SET_CW, CMD_RD_OP: arg_len = 3'd4;
      default:                        arg_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_frame_if.sv
// Byte-stream input and frame output of the command frame parser.
interface cmd_frame_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  cmd;
  logic [31:0] arg;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        frame_err;

  modport master (
    input  rx_data, rx_valid, cmd_ready,
    output rx_ready, cmd, arg, cmd_valid, frame_err
  );

  modport slave (
    output rx_data, rx_valid, cmd_ready,
    input  rx_ready, cmd, arg, cmd_valid, frame_err
  );
endinterface

// File: rtl/cmd_frame_timeout.sv
// Idle/stall counter: counts enabled cycles and flags expiry at TIMEOUT_CYCLES-1.
module cmd_frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TO_W           = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic expire_c
);

  logic [TO_W-1:0] cnt;

  assign expire_c = count_en && (cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Expiry restarts the count so the next idle period is measured from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || expire_c) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/cmd_frame_parser.sv
// Assembles host-link bytes into {cmd, arg} frames over a valid/ready handshake.
// Optional idle timeout / mid-frame abort enabled by CMD_FRAME_TIMEOUT_EN.
module cmd_frame_parser
  import cmd_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TO_W           = 17
) (
  input  logic         clk,
  input  logic         rst,
  cmd_frame_if.master  bus
);

  state_t     state;
  frame_t     frame_q;
  logic       rx_ready_q;
  logic       cmd_valid_q;
  logic [2:0] remaining;
  logic [1:0] idx;
  logic       rx_hs;
  logic       expire;
  logic [2:0] len_c;

  if ((64'd1 << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end

  assign rx_hs = bus.rx_valid & rx_ready_q;
  assign len_c = arg_len(bus.rx_data);

  assign bus.rx_ready  = rx_ready_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd       = frame_q.cmd;
  assign bus.arg       = frame_q.arg;

`ifdef CMD_FRAME_TIMEOUT_EN
  logic count_en;
  logic frame_err_q;

  // Frozen while a frame waits in OUT.
  assign count_en = (state != OUT) && !rx_hs;

  cmd_frame_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .count_en (count_en),
    .clear    (rx_hs),
    .expire_c (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= (state == ARG) && expire;
    end
  end

  assign bus.frame_err = frame_err_q;
`else
  assign expire        = 1'b0;
  assign bus.frame_err = 1'b0;
`endif

  // Frame FSM; rx_ready/cmd_valid are registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      frame_q     <= '0;
      rx_ready_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      remaining   <= '0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE: begin
          rx_ready_q <= 1'b1;
          if (rx_hs) begin
            frame_q.cmd <= bus.rx_data;
            frame_q.arg <= '0;
            remaining   <= len_c;
            idx         <= '0;
            if (len_c == 3'd0) begin
              state       <= OUT;
              rx_ready_q  <= 1'b0;
              cmd_valid_q <= 1'b1;
            end else begin
              state <= ARG;
            end
          end else if (expire) begin
            frame_q.cmd <= CMD_TIMEOUT;
            frame_q.arg <= '0;
            state       <= OUT;
            rx_ready_q  <= 1'b0;
            cmd_valid_q <= 1'b1;
          end
        end

        ARG: begin
          rx_ready_q <= 1'b1;
          if (rx_hs) begin
            frame_q.arg[{idx, 3'b000} +: 8] <= bus.rx_data;
            idx       <= idx + 2'd1;
            remaining <= remaining - 3'd1;
            if (remaining == 3'd1) begin
              state       <= OUT;
              rx_ready_q  <= 1'b0;
              cmd_valid_q <= 1'b1;
            end
          end else if (expire) begin
            state <= IDLE;
          end
        end

        OUT: begin
          if (bus.cmd_ready) begin
            state       <= IDLE;
            rx_ready_q  <= 1'b1;
            cmd_valid_q <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          rx_ready_q  <= 1'b0;
          cmd_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed self-checking bench for cmd_frame_parser (timeout steps under CMD_FRAME_TIMEOUT_EN).
module tb_cmd_frame_parser;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [39:0] frames[$];

  cmd_frame_if bus ();

  cmd_frame_parser #(
    .TIMEOUT_CYCLES (16),
    .TO_W           (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so a negedge sample predicts the handshake.
  always @(negedge clk) begin
    if (rst && bus.cmd_valid && bus.cmd_ready) frames.push_back({bus.cmd, bus.arg});
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [39:0] exp);
    chk({tag, "_present"}, 40'(frames.size() > 0), 40'd1);
    if (frames.size() > 0) chk(tag, frames.pop_front(), exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (bus.rx_ready === 1'b1) done = 1'b1;
      tick();
    end
    bus.rx_valid = 1'b0;
    chk("rx_accept", 40'(done), 40'd1);
  endtask

  initial begin
    bit ok;
    checks        = 0;
    errors        = 0;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.cmd_ready = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #3;
    chk("rst_rx_ready",  40'(bus.rx_ready),  40'd0);
    chk("rst_cmd_valid", 40'(bus.cmd_valid), 40'd0);
    chk("rst_cmd",       40'(bus.cmd),       40'd0);
    chk("rst_arg",       40'(bus.arg),       40'd0);
    chk("rst_frame_err", 40'(bus.frame_err), 40'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("idle_rx_ready", 40'(bus.rx_ready), 40'd1);

    // 4-byte argument frame, consumed immediately
    bus.cmd_ready = 1'b1;
    send_byte("M"); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    chk("m_valid",    40'(bus.cmd_valid), 40'd1);
    chk("m_frame",    {bus.cmd, bus.arg}, {8'h4d, 32'h12345678});
    chk("m_rx_ready", 40'(bus.rx_ready),  40'd0);
    tick();
    chk("m_valid_one_cycle", 40'(bus.cmd_valid), 40'd0);
    chk("m_rx_ready_back",   40'(bus.rx_ready),  40'd1);
    pop_chk("m_pop", {8'h4d, 32'h12345678});

    // 2-byte frame then a 0-arg frame back-to-back
    send_byte("A"); send_byte(8'h34); send_byte(8'h12);
    chk("a_frame",    {bus.cmd, bus.arg}, {8'h41, 32'h00001234});
    chk("a_rx_ready", 40'(bus.rx_ready),  40'd0);
    send_byte("b");
    chk("b_valid",    40'(bus.cmd_valid), 40'd1);
    chk("b_frame",    {bus.cmd, bus.arg}, {8'h62, 32'h0});
    chk("b_rx_ready", 40'(bus.rx_ready),  40'd0);
    tick();
    pop_chk("a_pop", {8'h41, 32'h00001234});
    pop_chk("b_pop", {8'h62, 32'h0});

    // Backpressure: frame held for 10 cycles
    bus.cmd_ready = 1'b0;
    send_byte("B"); send_byte(8'haa);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(bus.cmd_valid === 1'b1 && bus.rx_ready === 1'b0 &&
            {bus.cmd, bus.arg} === {8'h42, 32'h000000aa})) ok = 1'b0;
      tick();
    end
    chk("bp_held_stable", 40'(ok), 40'd1);
    chk("bp_no_early_pop", 40'(frames.size()), 40'd0);
    bus.cmd_ready = 1'b1;
    tick();
    chk("bp_released", 40'(bus.cmd_valid), 40'd0);
    pop_chk("bp_pop", {8'h42, 32'h000000aa});
    chk("bp_single", 40'(frames.size()), 40'd0);

    // Unknown code, a following 1-arg frame, and a received 8'hff
    send_byte("Z");
    chk("z_frame", {bus.cmd, bus.arg}, {8'h5a, 32'h0});
    send_byte("B"); send_byte(8'h55);
    chk("b55_frame", {bus.cmd, bus.arg}, {8'h42, 32'h00000055});
    send_byte(8'hff);
    chk("ff_byte_frame", {bus.cmd, bus.arg}, {8'hff, 32'h0});
    tick();
    pop_chk("z_pop",   {8'h5a, 32'h0});
    pop_chk("b55_pop", {8'h42, 32'h00000055});
    pop_chk("ffb_pop", {8'hff, 32'h0});

`ifdef CMD_FRAME_TIMEOUT_EN
    // Idle timeout: 16 idle cycles synthesize an 8'hff frame
    bus.cmd_ready = 1'b0;
    repeat (15) tick();
    chk("to_not_yet", 40'(bus.cmd_valid), 40'd0);
    tick();
    chk("to_valid", 40'(bus.cmd_valid), 40'd1);
    chk("to_frame", {bus.cmd, bus.arg}, {8'hff, 32'h0});
    bus.cmd_ready = 1'b1;
    tick();
    pop_chk("to_pop", {8'hff, 32'h0});

    // Mid-frame stall aborts the partial frame
    send_byte("O"); send_byte(8'h01);
    repeat (15) tick();
    chk("abort_not_yet", 40'(bus.frame_err), 40'd0);
    tick();
    chk("abort_err",      40'(bus.frame_err), 40'd1);
    chk("abort_no_frame", 40'(bus.cmd_valid), 40'd0);
    tick();
    chk("abort_err_pulse", 40'(bus.frame_err), 40'd0);
    send_byte("I");
    chk("abort_idle_frame", {bus.cmd, bus.arg}, {8'h49, 32'h0});
    tick();
    pop_chk("abort_i_pop", {8'h49, 32'h0});
    chk("abort_no_extra", 40'(frames.size()), 40'd0);
`endif

    // Asynchronous reset mid-frame
    send_byte("O"); send_byte(8'h01); send_byte(8'h02);
    rst = 1'b0;
    #1;
    chk("mid_rst_rx_ready",  40'(bus.rx_ready),  40'd0);
    chk("mid_rst_arg",       40'(bus.arg),       40'd0);
    chk("mid_rst_cmd",       40'(bus.cmd),       40'd0);
    chk("mid_rst_cmd_valid", 40'(bus.cmd_valid), 40'd0);
    chk("mid_rst_frame_err", 40'(bus.frame_err), 40'd0);
    tick();
    rst = 1'b1;
    send_byte("I");
    chk("post_rst_frame", {bus.cmd, bus.arg}, {8'h49, 32'h0});
    tick();
    pop_chk("post_rst_pop", {8'h49, 32'h0});
    chk("post_rst_no_extra", 40'(frames.size()), 40'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_frame_parser.md
Name: cmd_frame_parser

Overview:
- Upstream of the VM command handler. Consumes the raw serial byte stream from the host link and assembles command frames.
- A frame is one command byte followed by 0, 1, 2 or 4 little-endian argument bytes, with the count set by the command.
- Delivers each frame as {cmd, arg} over a valid/ready handshake, so the handler gets whole commands instead of polling bytes.
- Also synthesizes the 8'hff "read timeout" command when the link goes idle.

Parameters:
- TIMEOUT_CYCLES, 100000: idle cycles in IDLE before an 8'hff frame is emitted, and the mid-frame abort threshold.
- TO_W, 17: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data holds a byte.
- rx_ready  out  1  parser accepts the byte this cycle.
- cmd  out  8  command byte of the completed frame.
- arg  out  32  argument, zero-extended, little-endian assembled.
- cmd_valid  out  1  frame available.
- cmd_ready  in  1  handler consumes the frame.
- frame_err  out  1  one-cycle pulse when a partial frame is aborted.

Behaviour:
- Reset (rst=0, async): state=IDLE, rx_ready=0, cmd=0, arg=0, cmd_valid=0, frame_err=0, byte and timeout counters=0.
- Argument length table (ARG_LEN):
  - "B" = 1 byte.
  - "A" = 2 bytes.
  - "O", "M", "r" = 4 bytes.
  - All others = 0 bytes, including "I", "a", "b", "s", "f", "N", "c", "C", "T", "R", "Q" and unknown codes.
- IDLE:
  - rx_ready=1.
  - On a handshake (rx_valid & rx_ready): latch cmd, clear arg, and load remaining=ARG_LEN(cmd).
  - If remaining=0, go to OUT; otherwise go to ARG.
- ARG:
  - rx_ready=1.
  - Each handshake writes the byte into arg[8*idx +: 8], with idx counting from 0, and decrements remaining.
  - When the last byte is accepted, go to OUT.
- OUT:
  - rx_ready=0 and cmd_valid=1.
  - cmd and arg stay stable until cmd_ready=1, then return to IDLE.
  - cmd_valid deasserts in the cycle after the handshake.
- Latency: cmd_valid rises in the cycle after the last byte of the frame is accepted.
- Backpressure: cmd_valid must never drop without a handshake. Bytes are not accepted while in OUT; the upstream holds rx_valid.
- The byte after a frame is accepted no earlier than the cycle after the OUT handshake. There is no skid buffer.
- Unknown command bytes are forwarded unchanged with arg=0; rejecting them is the handler's job.
- An incoming byte value of 8'hff is treated as an ordinary 0-arg command.
- If rx_valid arrives at the same time as a timeout expiry, the byte wins and the timeout counter clears.
- Reset asserted mid-frame discards the partial frame; no frame_err pulse is generated.

Optional Feature:
- CMD_FRAME_TIMEOUT_EN defined:
  - The timeout counter increments each cycle in IDLE or ARG without a handshake, and clears on every handshake.
  - In IDLE at count TIMEOUT_CYCLES-1: emit the frame cmd=8'hff, arg=0 (enter OUT), then clear the counter.
  - In ARG at the same count: drop the partial frame, pulse frame_err for one cycle, return to IDLE, clear the counter, and emit no frame.
  - The counter is frozen in OUT.
- CMD_FRAME_TIMEOUT_EN undefined:
  - No counter logic is present.
  - frame_err is tied to 0.
  - 8'hff appears only when received as a byte.

Decomposition:
- Package cmd_frame_pkg holds:
  - the state enum {IDLE, ARG, OUT};
  - localparam command codes (CMD_WR_ADDR="A", CMD_WR_BUS="B", CMD_OFF="O", CMD_SET_CW="M", CMD_RD_OP="r", CMD_TIMEOUT=8'hff);
  - a function arg_len(cmd) returning 0..4.
- One sub-module, cmd_frame_timeout, is natural: counter, expiry compare and clear, compiled only under CMD_FRAME_TIMEOUT_EN.

Test Plan:
- Send bytes "M",0x78,0x56,0x34,0x12 with cmd_ready=1 -> one frame: cmd="M", arg=0x12345678, cmd_valid high for exactly one cycle.
- Send "A",0x34,0x12 then "b" back-to-back -> frames ("A",0x00001234) then ("b",0). rx_ready=0 while each frame waits in OUT.
- Send "B",0xAA with cmd_ready=0 for 10 cycles -> cmd_valid held with cmd/arg stable and rx_ready=0. On cmd_ready=1 the frame is consumed once.
- Send unknown "Z" -> frame ("Z",0) emitted with no argument bytes consumed; the next byte starts a new frame.
- With CMD_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=16: idle 16 cycles -> frame (8'hff,0). Send "O",0x01 then stall 16 cycles -> frame_err pulse, no frame, back in IDLE.
- Assert rst=0 asynchronously after "O",0x01,0x02 -> outputs clear immediately. Then "I" -> frame ("I",0).
